mtr_drv_pwm: RTL and testbench
==============================

// Module: mtr_drv_pwm
// PURPOSE
//  Motor-drive stage directly downstream of the heading PID. Consumes the signed
//  left/right wheel speeds and produces one forward and one reverse PWM output per
//  wheel for the H-bridges. A shared free-running 11-bit counter sets the period.
//  Duty and direction are double-buffered and change only at period boundaries.
// PARAMETERS
//  SLEW_STEP   64   max |duty| change per PWM period; used only when MTR_SLEW_EN defined
// PORTS
//  clk           in   1    system clock
//  rst_n         in   1    asynchronous active-low reset
//  lft_spd       in   12   signed left wheel speed command (from PID)
//  rght_spd      in   12   signed right wheel speed command (from PID)
//  lft_fwd_pwm   out  1    left H-bridge forward PWM
//  lft_rev_pwm   out  1    left H-bridge reverse PWM
//  rght_fwd_pwm  out  1    right H-bridge forward PWM
//  rght_rev_pwm  out  1    right H-bridge reverse PWM
//  pwm_sync      out  1    one-cycle pulse, high in the first cycle of each period
// BEHAVIOUR
//  - Reset (async, rst_n=0): cnt=0, active duties=0, all PWM outputs=0, pwm_sync=0.
//    Reset mid-period forces all outputs low immediately; after release the first
//    period starts with cnt=0.
//  - cnt: 11-bit unsigned, +1 every clk, wraps 2047->0; period = 2048 clk.
//  - Target per side: mag = |spd|, saturated to 2047 (-2048 -> 2047); dir = spd[11].
//  - Latch: in the cycle cnt==2047, each side's active {dir,duty} <= target
//    (or slewed target, see CONFIGURATION). Changes to spd at any other time have
//    no effect until the next latch. No glitch or partial period is allowed.
//  - Outputs are registered: fwd_pwm <= ~dir & (cnt < duty); rev_pwm <= dir & (cnt < duty).
//    Fixed one-clk lag from cnt; each period gives exactly duty high cycles,
//    contiguous, starting in the cycle after cnt==0.
//  - fwd and rev for one side are never both 1 (shoot-through forbidden).
//  - duty==0: both outputs low for the whole period (coast). spd==0 gives coast.
//  - pwm_sync registered: high exactly in the cycle the outputs begin a new
//    period (the cycle after cnt==0); aligned with the first high PWM cycle.
//  - Left and right channels are independent; both latch on the same edge.
// CONFIGURATION
//  MTR_SLEW_EN defined: the active signed duty (sign from dir, magnitude from duty)
//    moves toward the signed target by at most SLEW_STEP per latch; it passes
//    through 0 when reversing (dir changes only when the duty reaches 0);
//    when |target-active| <= SLEW_STEP the target is taken exactly.
//  MTR_SLEW_EN undefined: target is latched directly each period; SLEW_STEP unused.
// STRUCTURE
//  - Package mtr_drv_pkg: SPD_W=12, CNT_W=11, CNT_MAX=11'h7FF,
//    typedef logic signed [SPD_W-1:0] spd_t; typedef logic [CNT_W-1:0] duty_t.
//  - Sub-module mtr_pwm_chan (instantiated twice: left, right): abs/saturate,
//    optional slew, double-buffered {dir,duty}, compare and output flops.
//    Inputs: clk, rst_n, spd, cnt, latch. Counter and pwm_sync live in the top.
// TESTING
//  1 lft_spd=+512, rght_spd=0 -> per period lft_fwd high 512 clk, lft_rev 0,
//    right outputs stay 0; pwm_sync every 2048 clk.
//  2 rght_spd=-100 -> rght_rev high 100 clk/period, rght_fwd 0; never both high.
//  3 lft_spd=-2048 and +2047 -> high 2047 clk/period on rev/fwd resp. (saturation).
//  4 change lft_spd 200->800 at cnt=1000 -> current period keeps 200; next
//    period (after pwm_sync) gives 800.
//  5 rst_n low at cnt=300 with outputs high -> all outputs 0 at once; after
//    release first period starts at cnt=0 with duty 0, next period uses spd.
//  6 MTR_SLEW_EN, SLEW_STEP=64, lft_spd 0->+1000 -> duties 64,128,...,960,
//    then 1000 in period 16; then 1000->-100 -> ramps down by 64 to 40, then 0,
//    then rev 64, then rev 100.

Source files
------------

// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the motor-drive PWM stage.
// Optional feature macro used by this slice: MTR_SLEW_EN (duty slew limiting).
package mtr_drv_pkg;

    localparam int unsigned SPD_W = 12;
    localparam int unsigned CNT_W = 11;

    localparam logic [CNT_W-1:0] CNT_MAX = 11'h7FF;

    typedef logic signed [SPD_W-1:0] spd_t;
    typedef logic [CNT_W-1:0]        duty_t;

    // |spd| clipped to the duty range; -2048 would otherwise need 12 bits.
    function automatic duty_t spd_mag(input spd_t spd);
        logic [SPD_W-1:0] abs_v;
        abs_v = spd[SPD_W-1] ? SPD_W'(-spd) : SPD_W'(spd);
        return abs_v[SPD_W-1] ? CNT_MAX : abs_v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/mtr_drv_pwm_if.sv
// Speed-command / PWM-output bundle between the heading PID and the motor-drive stage.
// master: the side that commands speeds and observes PWM; slave: the drive stage.
interface mtr_drv_pwm_if;
    import mtr_drv_pkg::*;

    spd_t lft_spd;
    spd_t rght_spd;
    logic lft_fwd_pwm;
    logic lft_rev_pwm;
    logic rght_fwd_pwm;
    logic rght_rev_pwm;
    logic pwm_sync;

    modport master (
        output lft_spd,
        output rght_spd,
        input  lft_fwd_pwm,
        input  lft_rev_pwm,
        input  rght_fwd_pwm,
        input  rght_rev_pwm,
        input  pwm_sync
    );

    modport slave (
        input  lft_spd,
        input  rght_spd,
        output lft_fwd_pwm,
        output lft_rev_pwm,
        output rght_fwd_pwm,
        output rght_rev_pwm,
        output pwm_sync
    );

endinterface

// File: rtl/mtr_pwm_chan.sv
// One wheel's PWM channel: |spd| saturation, optional slew (MTR_SLEW_EN),
// double-buffered {dir,duty} updated on latch_i, and registered fwd/rev outputs.
module mtr_pwm_chan
    import mtr_drv_pkg::*;
#(
    parameter int unsigned SLEW_STEP = 64
) (
    input  logic  clk,
    input  logic  rst_n,
    input  spd_t  spd_i,
    input  duty_t cnt_i,
    input  logic  latch_i,
    output logic  fwd_pwm_o,
    output logic  rev_pwm_o
);

    logic  tgt_dir;
    duty_t tgt_duty;
    logic  lat_dir;
    duty_t lat_duty;

    logic  dir_q, dir_d;
    duty_t duty_q, duty_d;
    logic  fwd_q, rev_q;

    // Requested drive: direction from sign, magnitude saturated to 2047.
    always_comb begin
        tgt_dir  = spd_i[SPD_W-1];
        tgt_duty = spd_mag(spd_i);
    end

`ifdef MTR_SLEW_EN
    localparam logic signed [SPD_W+1:0] Step = (SPD_W+2)'(SLEW_STEP);

    logic signed [SPD_W+1:0] act_s;
    logic signed [SPD_W+1:0] tgt_s;
    logic signed [SPD_W+1:0] diff_s;
    logic signed [SPD_W+1:0] next_s;

    // Move the signed active duty toward the target by at most Step, stopping at 0 on reversal.
    always_comb begin
        act_s  = dir_q ? -$signed({3'b000, duty_q}) : $signed({3'b000, duty_q});
        tgt_s  = tgt_dir ? -$signed({3'b000, tgt_duty}) : $signed({3'b000, tgt_duty});
        diff_s = tgt_s - act_s;
        if (diff_s > Step) begin
            next_s = act_s + Step;
        end else if (diff_s < -Step) begin
            next_s = act_s - Step;
        end else begin
            next_s = tgt_s;
        end
        // A reversal must dwell one period at zero before the direction flips.
        if ((act_s > 0 && next_s < 0) || (act_s < 0 && next_s > 0)) begin
            next_s = '0;
        end
        lat_dir  = next_s < 0;
        lat_duty = CNT_W'(next_s < 0 ? -next_s : next_s);
    end
`else
    logic unused_slew_step;
    assign unused_slew_step = ^SLEW_STEP;

    // Without slew limiting the target is taken directly at every boundary.
    always_comb begin
        lat_dir  = tgt_dir;
        lat_duty = tgt_duty;
    end
`endif

    // Shadow-to-active transfer happens only on the period boundary.
    always_comb begin
        dir_d  = dir_q;
        duty_d = duty_q;
        if (latch_i) begin
            dir_d  = lat_dir;
            duty_d = lat_duty;
        end
    end

    // Active drive state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q  <= 1'b0;
            duty_q <= '0;
        end else begin
            dir_q  <= dir_d;
            duty_q <= duty_d;
        end
    end

    // Registered compare; dir gating makes fwd and rev mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= 1'b0;
            rev_q <= 1'b0;
        end else begin
            fwd_q <= ~dir_q & (cnt_i < duty_q);
            rev_q <= dir_q & (cnt_i < duty_q);
        end
    end

    assign fwd_pwm_o = fwd_q;
    assign rev_pwm_o = rev_q;

endmodule

// File: rtl/mtr_drv_pwm.sv
// Motor-drive PWM stage: shared 11-bit period counter, period-start sync pulse and
// two independent wheel channels. Optional slew limiting via MTR_SLEW_EN.
module mtr_drv_pwm
    import mtr_drv_pkg::*;
#(
    parameter int unsigned SLEW_STEP = 64
) (
    input logic          clk,
    input logic          rst_n,
    mtr_drv_pwm_if.slave drv_io
);

    duty_t cnt_q, cnt_d;
    logic  sync_q, sync_d;
    logic  latch;

    // Free-running counter; sync is registered so it lines up with the registered PWM.
    always_comb begin
        cnt_d  = cnt_q + duty_t'(1);
        sync_d = (cnt_q == '0);
        latch  = (cnt_q == CNT_MAX);
    end

    // Period counter and sync flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sync_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    mtr_pwm_chan #(
        .SLEW_STEP (SLEW_STEP)
    ) u_lft (
        .clk       (clk),
        .rst_n     (rst_n),
        .spd_i     (drv_io.lft_spd),
        .cnt_i     (cnt_q),
        .latch_i   (latch),
        .fwd_pwm_o (drv_io.lft_fwd_pwm),
        .rev_pwm_o (drv_io.lft_rev_pwm)
    );

    mtr_pwm_chan #(
        .SLEW_STEP (SLEW_STEP)
    ) u_rght (
        .clk       (clk),
        .rst_n     (rst_n),
        .spd_i     (drv_io.rght_spd),
        .cnt_i     (cnt_q),
        .latch_i   (latch),
        .fwd_pwm_o (drv_io.rght_fwd_pwm),
        .rev_pwm_o (drv_io.rght_rev_pwm)
    );

    assign drv_io.pwm_sync = sync_q;

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Directed bench for mtr_drv_pwm: per-period high-cycle counts, sync spacing,
// shoot-through, double buffering, saturation and mid-period reset.
// The MTR_SLEW_EN build runs the slew-ramp sequence instead.
module tb_mtr_drv_pwm;
    import mtr_drv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    int lf_n, lr_n, rf_n, rr_n, sync_n, shoot_n, lf_first, lf_rise;

    mtr_drv_pwm_if drv_if ();

    mtr_drv_pwm #(
        .SLEW_STEP (64)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .drv_io (drv_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bounded wait for the sync pulse, sampled on the falling edge.
    task automatic wait_sync(output logic ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 4200) begin
            @(negedge clk);
            n++;
            if (drv_if.pwm_sync === 1'b1) ok = 1'b1;
        end
    endtask

    // Observe one full period starting at the sync cycle (cnt==1 inside the DUT).
    // If chg_at > 0 the left speed is changed when the DUT counter equals chg_at.
    task automatic measure(input string tag, input int chg_at, input spd_t chg_lft);
        logic ok;
        logic prev;
        wait_sync(ok);
        check({tag, ".sync_seen"}, 32'(ok), 32'd1);
        lf_n = 0; lr_n = 0; rf_n = 0; rr_n = 0;
        sync_n = 0; shoot_n = 0; lf_first = 0; lf_rise = 0;
        prev = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            if (i > 0) @(negedge clk);
            if (drv_if.lft_fwd_pwm === 1'b1) lf_n++;
            if (drv_if.lft_rev_pwm === 1'b1) lr_n++;
            if (drv_if.rght_fwd_pwm === 1'b1) rf_n++;
            if (drv_if.rght_rev_pwm === 1'b1) rr_n++;
            if (drv_if.pwm_sync === 1'b1) sync_n++;
            if ((drv_if.lft_fwd_pwm === 1'b1 && drv_if.lft_rev_pwm === 1'b1) ||
                (drv_if.rght_fwd_pwm === 1'b1 && drv_if.rght_rev_pwm === 1'b1)) shoot_n++;
            if (i == 0 && drv_if.lft_fwd_pwm === 1'b1) lf_first = 1;
            if (!prev && drv_if.lft_fwd_pwm === 1'b1) lf_rise++;
            prev = (drv_if.lft_fwd_pwm === 1'b1);
            if (i + 1 == chg_at) drv_if.lft_spd = chg_lft;
        end
    endtask

    task automatic check_period(input string tag, input int e_lf, input int e_lr,
                                input int e_rf, input int e_rr);
        check({tag, ".lft_fwd"}, 32'(lf_n), 32'(e_lf));
        check({tag, ".lft_rev"}, 32'(lr_n), 32'(e_lr));
        check({tag, ".rght_fwd"}, 32'(rf_n), 32'(e_rf));
        check({tag, ".rght_rev"}, 32'(rr_n), 32'(e_rr));
        check({tag, ".sync_count"}, 32'(sync_n), 32'd1);
        check({tag, ".shoot_through"}, 32'(shoot_n), 32'd0);
        check({tag, ".lft_fwd_first"}, 32'(lf_first), (e_lf > 0) ? 32'd1 : 32'd0);
        check({tag, ".lft_fwd_runs"}, 32'(lf_rise), (e_lf > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic check_outputs_low(input string tag);
        check({tag, ".lft_fwd"}, 32'(drv_if.lft_fwd_pwm), 32'd0);
        check({tag, ".lft_rev"}, 32'(drv_if.lft_rev_pwm), 32'd0);
        check({tag, ".rght_fwd"}, 32'(drv_if.rght_fwd_pwm), 32'd0);
        check({tag, ".rght_rev"}, 32'(drv_if.rght_rev_pwm), 32'd0);
        check({tag, ".sync"}, 32'(drv_if.pwm_sync), 32'd0);
    endtask

    initial begin
        logic ok;
        rst_n = 1'b0;
`ifdef MTR_SLEW_EN
        drv_if.lft_spd  = 12'sd1000;
`else
        drv_if.lft_spd  = 12'sd512;
`endif
        drv_if.rght_spd = 12'sd0;
        repeat (3) @(negedge clk);
        check_outputs_low("reset");
        rst_n = 1'b1;

        // First period after reset always coasts.
        measure("post_reset", -1, 12'sd0);
        check_period("post_reset", 0, 0, 0, 0);

`ifdef MTR_SLEW_EN
        for (int k = 1; k <= 15; k++) begin
            measure($sformatf("up%0d", k), -1, 12'sd0);
            check_period($sformatf("up%0d", k), 64 * k, 0, 0, 0);
        end
        measure("up16", -1, 12'sd0);
        check_period("up16", 1000, 0, 0, 0);
        drv_if.lft_spd = -12'sd100;
        measure("rev_hold", -1, 12'sd0);
        check_period("rev_hold", 1000, 0, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            measure($sformatf("down%0d", k), -1, 12'sd0);
            check_period($sformatf("down%0d", k), 1000 - 64 * k, 0, 0, 0);
        end
        measure("zero_dwell", -1, 12'sd0);
        check_period("zero_dwell", 0, 0, 0, 0);
        measure("rev64", -1, 12'sd0);
        check_period("rev64", 0, 64, 0, 0);
        measure("rev100", -1, 12'sd0);
        check_period("rev100", 0, 100, 0, 0);
`else
        // Test 1: forward 512 on the left, right coasting.
        measure("t1", -1, 12'sd0);
        check_period("t1", 512, 0, 0, 0);

        // Test 2: right reverse 100; the period already latched keeps the old values.
        drv_if.rght_spd = -12'sd100;
        measure("t2_hold", -1, 12'sd0);
        check_period("t2_hold", 512, 0, 0, 0);
        measure("t2", -1, 12'sd0);
        check_period("t2", 512, 0, 0, 100);

        // Test 3: saturation at both extremes on both sides.
        drv_if.lft_spd  = -12'sd2048;
        drv_if.rght_spd = 12'sd2047;
        measure("t3a_skip", -1, 12'sd0);
        measure("t3a", -1, 12'sd0);
        check_period("t3a", 0, 2047, 2047, 0);
        drv_if.lft_spd  = 12'sd2047;
        drv_if.rght_spd = -12'sd2048;
        measure("t3b_skip", -1, 12'sd0);
        measure("t3b", -1, 12'sd0);
        check_period("t3b", 2047, 0, 0, 2047);

        // Test 4: mid-period speed change waits for the next boundary.
        drv_if.lft_spd  = 12'sd200;
        drv_if.rght_spd = 12'sd0;
        measure("t4_skip", -1, 12'sd0);
        measure("t4_cur", 1000, 12'sd800);
        check_period("t4_cur", 200, 0, 0, 0);
        measure("t4_next", -1, 12'sd0);
        check_period("t4_next", 800, 0, 0, 0);

        // Test 5: reset at cnt==300 while the left forward output is high.
        wait_sync(ok);
        check("t5.sync_seen", 32'(ok), 32'd1);
        repeat (299) @(negedge clk);
        check("t5.pre_reset_high", 32'(drv_if.lft_fwd_pwm), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_low("t5.in_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure("t5_first", -1, 12'sd0);
        check_period("t5_first", 0, 0, 0, 0);
        measure("t5_next", -1, 12'sd0);
        check_period("t5_next", 800, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
